micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_seq_pkg.sv | 15 +
 rtl/micro_ret_reg.sv | 24 ++
 rtl/micro_sequencer.sv | 89 ++++++++
 tb/tb_micro_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared cond encodings, FSM states and address constants for micro_sequencer
package micro_seq_pkg;
    localparam int UADDR_W = 5;
    localparam logic [UADDR_W-1:0] FETCH_ADDR = 5'b00000;
    localparam logic [UADDR_W-1:0] NOMAP_ADDR = 5'b11111;
    localparam logic [2:0] COND_INC   = 3'b000;
    localparam logic [2:0] COND_JMP   = 3'b001;
    localparam logic [2:0] COND_JZ    = 3'b010;
    localparam logic [2:0] COND_JNZ   = 3'b011;
    localparam logic [2:0] COND_MAP   = 3'b100;
    localparam logic [2:0] COND_FETCH = 3'b101;
    localparam logic [2:0] COND_CALL  = 3'b110;
    localparam logic [2:0] COND_RET   = 3'b111;
    typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;
endpackage

// File: rtl/micro_ret_reg.sv
// micro_ret_reg: one-entry micro-call return register used when USTACK_EN is defined
module micro_ret_reg
    import micro_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [UADDR_W-1:0] d,
    output logic [UADDR_W-1:0] ret_addr,
    output logic               ret_valid
);
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_addr  <= '0;
            ret_valid <= 1'b0;
        end else if (push) begin
            ret_addr  <= d;
            ret_valid <= 1'b1;
        end else if (pop) begin
            ret_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC sequencer with wait/halt FSM and dispatch counter; USTACK_EN adds call/return
module micro_sequencer
    import micro_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [UADDR_W-1:0] map_addr,
    input  logic [UADDR_W-1:0] next_addr,
    input  logic [2:0]         cond,
    input  logic               z,
    input  logic               mem_wait,
    output logic [UADDR_W-1:0] upc,
    output logic               halted,
    output logic               err,
    output logic [15:0]        disp_cnt
);
    state_t             state, state_n;
    logic [UADDR_W-1:0] upc_n, inc;
    logic [15:0]        cnt_n;
    logic               err_n, fault;
`ifdef USTACK_EN
    logic               push, pop, ret_valid;
    logic [UADDR_W-1:0] ret_addr;
    micro_ret_reg u_ret (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .d(inc),
        .ret_addr(ret_addr), .ret_valid(ret_valid)
    );
`endif
    assign inc    = upc + 5'd1;
    assign halted = (state == HALT);
    always_comb begin
        state_n = state;
        upc_n   = upc;
        err_n   = err;
        cnt_n   = disp_cnt;
        fault   = 1'b0;
`ifdef USTACK_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        if (state != HALT && mem_wait) state_n = WAIT;
        else if (state != HALT) begin
            state_n = RUN;
            case (cond)
                COND_INC:   upc_n = inc;
                COND_JMP:   upc_n = next_addr;
                COND_JZ:    upc_n = z ? next_addr : inc;
                COND_JNZ:   upc_n = z ? inc : next_addr;
                COND_MAP: begin
                    fault = (map_addr == NOMAP_ADDR);
                    upc_n = fault ? upc : map_addr;
                    cnt_n = (fault || &disp_cnt) ? disp_cnt : disp_cnt + 16'd1;
                end
                COND_FETCH: upc_n = FETCH_ADDR;
`ifdef USTACK_EN
                COND_CALL: begin
                    fault = ret_valid;
                    push  = !ret_valid;
                    upc_n = ret_valid ? upc : next_addr;
                end
                COND_RET: begin
                    fault = !ret_valid;
                    pop   = ret_valid;
                    upc_n = ret_valid ? ret_addr : upc;
                end
`else
                default:    upc_n = inc;
`endif
            endcase
            if (fault) begin
                state_n = HALT;
                err_n   = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            upc      <= FETCH_ADDR;
            err      <= 1'b0;
            disp_cnt <= '0;
        end else begin
            state    <= state_n;
            upc      <= upc_n;
            err      <= err_n;
            disp_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed self-checking bench for micro_sequencer (either USTACK_EN build)
module tb_micro_sequencer;
    logic        clk = 1'b0, rst = 1'b1, z = 1'b0, mem_wait = 1'b0;
    logic [4:0]  map_addr = '0, next_addr = '0, upc;
    logic [2:0]  cond = '0;
    logic        halted, err;
    logic [15:0] disp_cnt;
    int checks = 0, failures = 0;

    micro_sequencer dut (
        .clk(clk), .rst(rst), .map_addr(map_addr), .next_addr(next_addr), .cond(cond),
        .z(z), .mem_wait(mem_wait), .upc(upc), .halted(halted), .err(err), .disp_cnt(disp_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_wait = 1'b0; cond = 3'b000;
        step();
        rst = 1'b0;
    endtask

    task automatic jump_to(input logic [4:0] a);
        cond = 3'b001; next_addr = a; mem_wait = 1'b0;
        step();
        checks++; if (upc !== a) begin failures++; $display("FAIL jump_to got=%0d exp=%0d", upc, a); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cond = 3'b100; map_addr = 5'b11111; mem_wait = 1'b1; z = 1'b1;
        step();
        checks++; if (upc !== 5'd0) begin failures++; $display("FAIL reset_upc got=%0d exp=0", upc); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (disp_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", disp_cnt); end
        rst = 1'b0; mem_wait = 1'b0; z = 1'b0;
    endtask

    task automatic test_inc();
        do_reset();
        cond = 3'b000;
        for (int i = 1; i <= 33; i++) begin
            step();
            checks++; if (upc !== 5'(i % 32)) begin failures++; $display("FAIL inc_wrap step=%0d got=%0d exp=%0d", i, upc, i % 32); end
        end
        checks++; if (disp_cnt !== 16'd0) begin failures++; $display("FAIL inc_cnt got=%h exp=0", disp_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        jump_to(5'd5);
        cond = 3'b010; next_addr = 5'd9; z = 1'b1; step();
        checks++; if (upc !== 5'd9) begin failures++; $display("FAIL jz_taken got=%0d exp=9", upc); end
        jump_to(5'd5);
        cond = 3'b010; next_addr = 5'd9; z = 1'b0; step();
        checks++; if (upc !== 5'd6) begin failures++; $display("FAIL jz_not_taken got=%0d exp=6", upc); end
        jump_to(5'd5);
        cond = 3'b011; next_addr = 5'd9; z = 1'b0; step();
        checks++; if (upc !== 5'd9) begin failures++; $display("FAIL jnz_taken got=%0d exp=9", upc); end
        cond = 3'b011; next_addr = 5'd20; z = 1'b1; step();
        checks++; if (upc !== 5'd10) begin failures++; $display("FAIL jnz_not_taken got=%0d exp=10", upc); end
        cond = 3'b101; step();
        checks++; if (upc !== 5'd0) begin failures++; $display("FAIL fetch got=%0d exp=0", upc); end
        z = 1'b0;
    endtask

    task automatic test_map();
        do_reset();
        cond = 3'b100; map_addr = 5'b10001; step();
        checks++; if (upc !== 5'd17) begin failures++; $display("FAIL map_upc got=%0d exp=17", upc); end
        checks++; if (disp_cnt !== 16'd1) begin failures++; $display("FAIL map_cnt got=%h exp=1", disp_cnt); end
        map_addr = 5'b11111; step();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL nomap_halted got=%b exp=1", halted); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL nomap_err got=%b exp=1", err); end
        checks++; if (upc !== 5'd17) begin failures++; $display("FAIL nomap_upc got=%0d exp=17", upc); end
        checks++; if (disp_cnt !== 16'd1) begin failures++; $display("FAIL nomap_cnt got=%h exp=1", disp_cnt); end
        cond = 3'b101;
        for (int i = 0; i < 3; i++) begin
            mem_wait = (i == 1);
            step();
            checks++; if (halted !== 1'b1 || upc !== 5'd17 || err !== 1'b1) begin failures++; $display("FAIL halt_hold i=%0d halted=%b upc=%0d err=%b exp=1/17/1", i, halted, upc, err); end
        end
        mem_wait = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        checks++; if (upc !== 5'd0 || err !== 1'b0 || halted !== 1'b0 || disp_cnt !== 16'd0) begin failures++; $display("FAIL halt_reset upc=%0d err=%b halted=%b cnt=%h exp=0/0/0/0", upc, err, halted, disp_cnt); end
    endtask

    task automatic test_wait();
        do_reset();
        cond = 3'b100; map_addr = 5'd4; mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (upc !== 5'd0 || disp_cnt !== 16'd0) begin failures++; $display("FAIL wait_hold i=%0d upc=%0d cnt=%h exp=0/0", i, upc, disp_cnt); end
        end
        map_addr = 5'b11111; step();
        checks++; if (halted !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL wait_priority halted=%b err=%b exp=0/0", halted, err); end
        map_addr = 5'd4; mem_wait = 1'b0; step();
        checks++; if (upc !== 5'd4) begin failures++; $display("FAIL wait_release_upc got=%0d exp=4", upc); end
        checks++; if (disp_cnt !== 16'd1) begin failures++; $display("FAIL wait_release_cnt got=%h exp=1", disp_cnt); end
    endtask

    task automatic test_ustack();
        do_reset();
        jump_to(5'd7);
`ifdef USTACK_EN
        cond = 3'b110; next_addr = 5'd20; step();
        checks++; if (upc !== 5'd20) begin failures++; $display("FAIL call_upc got=%0d exp=20", upc); end
        cond = 3'b111; step();
        checks++; if (upc !== 5'd8 || halted !== 1'b0) begin failures++; $display("FAIL ret_upc got=%0d halted=%b exp=8/0", upc, halted); end
        step();
        checks++; if (halted !== 1'b1 || err !== 1'b1 || upc !== 5'd8) begin failures++; $display("FAIL ret_underflow halted=%b err=%b upc=%0d exp=1/1/8", halted, err, upc); end
        do_reset();
        jump_to(5'd31);
        cond = 3'b110; next_addr = 5'd20; step();
        cond = 3'b110; next_addr = 5'd3; step();
        checks++; if (halted !== 1'b1 || err !== 1'b1 || upc !== 5'd20) begin failures++; $display("FAIL call_overflow halted=%b err=%b upc=%0d exp=1/1/20", halted, err, upc); end
        do_reset();
        cond = 3'b111; step();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL ret_cleared_by_rst halted=%b exp=1", halted); end
`else
        cond = 3'b110; next_addr = 5'd20; step();
        checks++; if (upc !== 5'd8) begin failures++; $display("FAIL cond110_inc got=%0d exp=8", upc); end
        cond = 3'b111; step();
        checks++; if (upc !== 5'd9 || halted !== 1'b0) begin failures++; $display("FAIL cond111_inc got=%0d halted=%b exp=9/0", upc, halted); end
`endif
    endtask

    task automatic test_saturate();
        do_reset();
        cond = 3'b100; map_addr = 5'd1;
        for (int i = 0; i < 65534; i++) step();
        checks++; if (disp_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", disp_cnt); end
        step();
        checks++; if (disp_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h exp=ffff", disp_cnt); end
        step();
        checks++; if (disp_cnt !== 16'hFFFF || upc !== 5'd1) begin failures++; $display("FAIL sat_hold cnt=%h upc=%0d exp=ffff/1", disp_cnt, upc); end
    endtask

    task automatic test_reset_mid_wait();
        cond = 3'b001; next_addr = 5'd12; mem_wait = 1'b1; step();
        checks++; if (upc !== 5'd1) begin failures++; $display("FAIL pre_wait_upc got=%0d exp=1", upc); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (upc !== 5'd0 || halted !== 1'b0 || err !== 1'b0 || disp_cnt !== 16'd0) begin failures++; $display("FAIL wait_reset upc=%0d halted=%b err=%b cnt=%h exp=0/0/0/0", upc, halted, err, disp_cnt); end
        mem_wait = 1'b0; cond = 3'b000; step();
        checks++; if (upc !== 5'd1) begin failures++; $display("FAIL post_reset_first got=%0d exp=1", upc); end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_branch();
        test_map();
        test_wait();
        test_ustack();
        test_saturate();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
